// File: rtl/instruction_fetch_controller.sv
// Fetches a 16-bit instruction as two bytes over an 8-bit memory bus, low byte first.
// The controller owns the PC and drives the IR Write/LH strobes.
module instruction_fetch_controller #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    input  logic              MemAck,
    input  logic [7:0]        MemData,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [ADDR_W-1:0] PCOut,
    output logic [7:0]        IRData,
    output logic              IRWrite,
    output logic              IRLH,
    output logic              Busy,
    output logic              Done,
    output logic              Fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, FAULT} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   wait_cnt;
    logic               resume_hi;
    logic               in_req, in_wait, timeout_hit;

    assign in_req      = (state == REQ_LO) || (state == REQ_HI);
    assign in_wait     = (state == IDLE) || (state == FAULT);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign MemAddr     = pc;
    assign PCOut       = pc;

    // A restart after a fault resumes at the byte that timed out, so a failed
    // high byte is refetched alone from the PC that still points at it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = REQ_LO;
            FAULT:   if (Start) state_nxt = resume_hi ? REQ_HI : REQ_LO;
            REQ_LO:  if (MemAck) state_nxt = WR_LO;
                     else if (timeout_hit) state_nxt = FAULT;
            WR_LO:   state_nxt = REQ_HI;
            REQ_HI:  if (MemAck) state_nxt = WR_HI;
                     else if (timeout_hit) state_nxt = FAULT;
            WR_HI:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            wait_cnt  <= '0;
            resume_hi <= 1'b0;
            IRData    <= '0;
            MemReq    <= 1'b0;
            IRWrite   <= 1'b0;
            IRLH      <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + 1'b1;
            // Outputs are decoded from the next state so they align with it.
            MemReq   <= (state_nxt == REQ_LO) || (state_nxt == REQ_HI);
            IRWrite  <= (state_nxt == WR_LO) || (state_nxt == WR_HI);
            IRLH     <= (state_nxt == WR_HI);
            Busy     <= (state_nxt != IDLE) && (state_nxt != FAULT);
            Done     <= (state == WR_HI);

            if (in_wait && PCLoad)
                pc <= PCIn;
            if (in_req && MemAck) begin
                IRData <= MemData;
                pc     <= pc + 1'b1;
            end

            if (in_req && state_nxt == FAULT) begin
                Fault     <= 1'b1;
                resume_hi <= (state == REQ_HI);
            end else if (in_wait && Start) begin
                Fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Randomized bench for instruction_fetch_controller; expected cycles come from a
// transaction-level model of the two-byte fetch with per-byte ack delays.
module tb_instruction_fetch_controller;

    localparam int          TO    = 4;
    localparam logic [15:0] RSTPC = 16'h0040;

    logic        Clock = 1'b0;
    logic        Reset, Start, PCLoad, MemAck;
    logic [15:0] PCIn;
    logic [7:0]  MemData;
    logic        MemReq, IRWrite, IRLH, Busy, Done, Fault;
    logic [15:0] MemAddr, PCOut;
    logic [7:0]  IRData;

    instruction_fetch_controller #(.ADDR_W(16), .RESET_PC(RSTPC), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
        .MemAck(MemAck), .MemData(MemData), .MemReq(MemReq), .MemAddr(MemAddr),
        .PCOut(PCOut), .IRData(IRData), .IRWrite(IRWrite), .IRLH(IRLH),
        .Busy(Busy), .Done(Done), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          req;
        bit          ack;
        bit          wr;
        bit          lh;
        bit          busy;
        bit          fault;
        bit          done;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [7:0]  data;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [7:0]  mem [0:65535];
    logic [15:0] m_pc;
    bit          m_fault, m_hi;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle behaviour of one fetch, starting the cycle after Start.
    task automatic build(input logic [15:0] pc_in, input int first, input int d0, input int d1);
        cyc_t c;
        logic [15:0] pc = pc_in;
        int d;
        for (int h = first; h < 2; h++) begin
            d = (h == 1) ? d1 : d0;
            c = '{default: 0};
            c.req = 1; c.busy = 1; c.addr = pc; c.pc = pc;
            for (int k = 0; k <= d && k < TO; k++) begin
                c.ack = (k == d);
                exp_q.push_back(c);
            end
            if (d >= TO) begin
                c = '{default: 0};
                c.fault = 1; c.pc = pc;
                exp_q.push_back(c);
                m_pc = pc; m_fault = 1; m_hi = (h == 1);
                return;
            end
            c = '{default: 0};
            c.wr = 1; c.lh = (h == 1); c.busy = 1; c.data = mem[pc];
            pc = pc + 16'd1;
            c.pc = pc;
            exp_q.push_back(c);
        end
        c = '{default: 0};
        c.done = 1; c.pc = pc;
        exp_q.push_back(c);
        m_pc = pc; m_fault = 0; m_hi = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"}, MemReq, 0);
        chk({tag, "_wr"}, IRWrite, 0);
        chk({tag, "_lh"}, IRLH, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_fault"}, Fault, 0);
        chk({tag, "_ir"}, IRData, 0);
        chk({tag, "_pc"}, PCOut, RSTPC);
    endtask

    task automatic run_fetch(input bit load, input logic [15:0] newpc,
                             input int d0, input int d1, input int rst_at);
        cyc_t e;
        int first;
        @(negedge Clock);
        if (load) m_pc = newpc;
        first = m_fault ? int'(m_hi) : 0;
        exp_q.delete();
        build(m_pc, first, d0, d1);
        Start = 1; PCLoad = load; PCIn = newpc; MemAck = 1'($urandom);
        foreach (exp_q[i]) begin
            @(negedge Clock);
            e = exp_q[i];
            chk("req", MemReq, e.req);
            if (e.req) chk("addr", MemAddr, e.addr);
            chk("irwrite", IRWrite, e.wr);
            if (e.wr) begin
                chk("irlh", IRLH, e.lh);
                chk("irdata", IRData, e.data);
            end
            chk("busy", Busy, e.busy);
            chk("done", Done, e.done);
            chk("fault", Fault, e.fault);
            chk("pc", PCOut, e.pc);
            if (e.busy) begin
                Start = 1'($urandom); PCLoad = 1'($urandom); PCIn = 16'($urandom);
            end else begin
                Start = 0; PCLoad = 0;
            end
            MemAck  = e.req ? e.ack : 1'($urandom);
            MemData = (e.req && e.ack) ? mem[e.addr] : 8'($urandom);
            if (i == rst_at) begin
                Reset = 0;
                @(negedge Clock);
                check_reset_state("rst_mid");
                Reset = 1;
                m_pc = RSTPC; m_fault = 0; m_hi = 0;
                break;
            end
        end
        Start = 0; PCLoad = 0; MemAck = 0;
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge Clock);
            chk("idle_busy", Busy, 0);
            chk("idle_req", MemReq, 0);
            chk("idle_wr", IRWrite, 0);
            chk("idle_done", Done, 0);
            chk("idle_fault", Fault, m_fault);
            chk("idle_pc", PCOut, m_pc);
            MemAck = 1'($urandom);
        end
        MemAck = 0;
    endtask

    initial begin
        int d0, d1;
        bit ld;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        Reset = 0; Start = 0; PCLoad = 0; PCIn = 0; MemAck = 0; MemData = 0;
        m_pc = RSTPC; m_fault = 0; m_hi = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_reset_state("reset");
        Reset = 1;

        run_fetch(1, 16'h0010, 0, 0, -1);
        chk("t1_pc", PCOut, 16'h0012);
        idle_check(2);
        run_fetch(0, 16'h0000, 3, 3, -1);
        idle_check(1);
        run_fetch(0, 16'h0000, 0, 20, -1);
        idle_check(3);
        run_fetch(0, 16'h0000, 0, 0, -1);
        run_fetch(1, 16'hFFFF, 0, 0, -1);
        chk("t4_pc", PCOut, 16'h0001);
        run_fetch(0, 16'h0000, 0, 0, 1);
        idle_check(2);
        run_fetch(0, 16'h0000, 9, 0, -1);
        run_fetch(0, 16'h0000, 1, 2, -1);

        for (int t = 0; t < 40; t++) begin
            d0 = $urandom_range(0, 5);
            d1 = $urandom_range(0, 5);
            ld = !m_fault && ($urandom_range(0, 3) == 0);
            run_fetch(ld, 16'($urandom), d0, d1, ($urandom_range(0, 9) == 0) ? 2 : -1);
            if ($urandom_range(0, 2) == 0) idle_check($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
